// File: rtl/iso14443a_app_echo_pkg.sv
// rtl/iso14443a_app_echo_pkg.sv - shared types and constants for the app echo responder
// Optional feature macro: ISO14443A_APP_STATUS_BYTE_EN (adds a one-byte status prefix to every reply)
package iso14443a_app_echo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        TX   = 2'd2
    } app_echo_state_e;

`ifdef ISO14443A_APP_STATUS_BYTE_EN
    // Number of prefix bytes placed ahead of the echoed data
    localparam int APP_ECHO_STATUS_PREFIX_W = 1;
`else
    localparam int APP_ECHO_STATUS_PREFIX_W = 0;
`endif

endpackage

// File: rtl/iso14443a_app_echo_pingpong_ram.sv
// rtl/iso14443a_app_echo_pingpong_ram.sv - two-bank DEPTH x 8 byte store, one write port, one combinational read port
// Ports:
//   clk      in   clock
//   we       in   write enable
//   wr_bank  in   bank written
//   wr_addr  in   byte address within wr_bank
//   wr_data  in   byte written
//   rd_bank  in   bank read
//   rd_addr  in   byte address within rd_bank
//   rd_data  out  combinational read data
module app_echo_pingpong_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // Bank select is the MSB of the flat address
    logic [7:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/iso14443a_app_echo.sv
// rtl/iso14443a_app_echo.sv - loopback application: captures an INF field and replies with it XOR'd by XOR_MASK
// Optional feature macro: ISO14443A_APP_STATUS_BYTE_EN (prefix every reply with {1'b0, len[6:0]})
// Ports:
//   clk              in   core clock
//   rst              in   synchronous active-high reset
//   rx_soc           in   start of received INF field
//   rx_data          in   received byte
//   rx_data_valid    in   rx_data valid this cycle
//   rx_eoc           in   end of received INF field
//   rx_error         in   corrupt-message flag, sampled with rx_eoc
//   app_resend_last  in   retransmit previous reply
//   tx_data          out  reply byte
//   tx_data_valid    out  tx_data/tx_last_byte valid, held until consumed
//   tx_last_byte     out  final byte of the reply
//   tx_req           in   downstream takes the byte when tx_req && tx_data_valid
//   busy             out  responder not idle
module iso14443a_app_echo
    import iso14443a_app_echo_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  XOR_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_soc,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    input  logic       rx_eoc,
    input  logic       rx_error,
    input  logic       app_resend_last,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    output logic       tx_last_byte,
    input  logic       tx_req,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    app_echo_state_e state, state_next;

    logic          bank_sel;      // bank holding the last good message
    logic          last_valid;
    logic [LW-1:0] len_q [2];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic          ovf;
    logic          tx_valid;

    logic          start_rx;
    logic          start_tx;
    logic          commit;
    logic          wr_en;
    logic          set_ovf;
    logic          tx_show;
    logic          tx_take;
    logic          tx_done;

    logic [LW-1:0] len_act;
    logic          reply_last;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    reply_byte;

    assign len_act    = len_q[bank_sel];
    assign reply_last = (rd_ptr == len_act + LW'(APP_ECHO_STATUS_PREFIX_W) - LW'(1));

`ifdef ISO14443A_APP_STATUS_BYTE_EN
    // Index 0 is the status byte, so data is fetched one position behind rd_ptr
    assign rd_addr    = AW'(rd_ptr - LW'(1));
    assign reply_byte = (rd_ptr == '0) ? (8'(len_act) & 8'h7F) : (rd_data ^ XOR_MASK);
`else
    assign rd_addr    = rd_ptr[AW-1:0];
    assign reply_byte = rd_data ^ XOR_MASK;
`endif

    app_echo_pingpong_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (~bank_sel),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (rx_data),
        .rd_bank (bank_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_next = state;
        start_rx   = 1'b0;
        start_tx   = 1'b0;
        commit     = 1'b0;
        wr_en      = 1'b0;
        set_ovf    = 1'b0;
        tx_show    = 1'b0;
        tx_take    = 1'b0;
        tx_done    = 1'b0;
        case (state)
            IDLE: begin
                // rx_soc takes priority over a simultaneous resend request
                if (rx_soc) begin
                    start_rx   = 1'b1;
                    state_next = RX;
                end else if (app_resend_last && last_valid) begin
                    start_tx   = 1'b1;
                    state_next = TX;
                end
            end
            RX: begin
                if (rx_soc) begin
                    start_rx = 1'b1;
                end else if (rx_eoc) begin
                    if (rx_error || ovf || (wr_ptr == '0)) begin
                        state_next = IDLE;
                    end else begin
                        commit     = 1'b1;
                        start_tx   = 1'b1;
                        state_next = TX;
                    end
                end else if (rx_data_valid) begin
                    if (wr_ptr == LW'(DEPTH)) begin
                        set_ovf = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            TX: begin
                if (rx_soc) begin
                    start_rx   = 1'b1;
                    state_next = RX;
                end else if (!tx_valid) begin
                    tx_show = 1'b1;
                end else if (tx_req) begin
                    if (reply_last) begin
                        tx_done    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tx_take = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bank_sel   <= 1'b0;
            last_valid <= 1'b0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ovf        <= 1'b0;
            tx_valid   <= 1'b0;
        end else begin
            state <= state_next;
            if (start_rx) begin
                wr_ptr   <= '0;
                ovf      <= 1'b0;
                tx_valid <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (set_ovf) begin
                ovf <= 1'b1;
            end
            // Freshly written bank becomes the active one
            if (commit) begin
                len_q[~bank_sel] <= wr_ptr;
                bank_sel         <= ~bank_sel;
                last_valid       <= 1'b1;
            end
            if (start_tx) begin
                rd_ptr   <= '0;
                tx_valid <= 1'b0;
            end
            if (tx_show) begin
                tx_valid <= 1'b1;
            end
            if (tx_take) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            if (tx_done) begin
                tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data_valid = tx_valid;
    assign tx_data       = tx_valid ? reply_byte : 8'h00;
    assign tx_last_byte  = tx_valid & reply_last;
    assign busy          = (state != IDLE);

endmodule
